// File: rtl/wiscsc15_mc_ctrl.sv
// Multi-cycle control FSM for the WISC-SC15 core.
// Sequences fetch / decode / execute / memory / writeback, handshakes with the
// instruction and data memories, and drives the datapath select lines.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for run; no requests outstanding
// FETCH  | imem_req held until imem_ack; IR and PC+1 latched on the ack
// DECODE | opcode resolved; halt opcode (or undefined) goes to HALT
// EXEC   | ALU controls valid; branch resolves and retires here
// MEM    | dm_read / dm_write held until dmem_ack; sw retires here
// WB     | register write, call/ret PC update, retire
// HALT   | absorbing; halted=1, leave only through rst_n
// ERR    | absorbing; memory wait timed out, err=1, leave only via rst_n
//
// Outputs are decoded from the registered state and the opcode. The fetch
// strobes and the taken-branch PC write also follow the ack / br_taken
// inputs, so they land in the same cycle the memory or comparator answers.
module wiscsc15_mc_ctrl #(
    parameter int                OPC_W    = 4,
    parameter int                ALUOP_W  = 3,
    parameter int                TMO_W    = 4,
    parameter int                CNT_W    = 16,
    parameter logic [OPC_W-1:0]  HALT_OPC = OPC_W'(4'b1111)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               br_taken,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               ir_load,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               rf_w,
    output logic [1:0]         rf_rsrc1,
    output logic [1:0]         rf_rsrc2,
    output logic [1:0]         rf_data,
    output logic               alu_src1,
    output logic [1:0]         alu_src2,
    output logic [ALUOP_W-1:0] aluop,
    output logic               dm_read,
    output logic               dm_write,
    output logic               halted,
    output logic               err,
    output logic [CNT_W-1:0]   icount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    typedef enum logic [3:0] {
        C_ARITH, C_INC, C_SHIFT, C_LW, C_SW, C_LHB, C_LLB,
        C_BR, C_CALL, C_RET, C_HALT
    } cls_t;

    localparam logic [OPC_W-1:0] OP_AR_MAX = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_INC    = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_SLL    = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SRL    = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SRA    = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_LW     = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SW     = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_LHB    = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_LLB    = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_B      = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_CALL   = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_RET    = OPC_W'(14);

    localparam logic [TMO_W-1:0] TMO_LIM   = '1;

    state_t           state;
    cls_t             cls;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             tmo_hit;

    // Opcode class; the halt opcode and anything unlisted both stop the core
    always_comb begin
        cls = C_HALT;
        if (opcode != HALT_OPC) begin
            if (opcode <= OP_AR_MAX) begin
                cls = C_ARITH;
            end else begin
                case (opcode)
                    OP_INC:                 cls = C_INC;
                    OP_SLL, OP_SRL, OP_SRA: cls = C_SHIFT;
                    OP_LW:                  cls = C_LW;
                    OP_SW:                  cls = C_SW;
                    OP_LHB:                 cls = C_LHB;
                    OP_LLB:                 cls = C_LLB;
                    OP_B:                   cls = C_BR;
                    OP_CALL:                cls = C_CALL;
                    OP_RET:                 cls = C_RET;
                    default:                cls = C_HALT;
                endcase
            end
        end
    end

    // The wait that would make the counter reach its limit is the last one allowed
    always_comb begin
        tmo_nxt = tmo_cnt + 1'b1;
        tmo_hit = (tmo_nxt == TMO_LIM);
    end

    // State sequencing, memory-wait timeout and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
            icount  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_FETCH;
                        tmo_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state <= S_DECODE;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        if (tmo_hit) state <= S_ERR;
                    end
                end
                S_DECODE: begin
                    state <= (cls == C_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    case (cls)
                        C_BR: begin
                            icount  <= icount + 1'b1;
                            tmo_cnt <= '0;
                            state   <= run ? S_FETCH : S_IDLE;
                        end
                        C_LW, C_SW, C_CALL, C_RET: begin
                            tmo_cnt <= '0;
                            state   <= S_MEM;
                        end
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (cls == C_SW) begin
                            icount  <= icount + 1'b1;
                            tmo_cnt <= '0;
                            state   <= run ? S_FETCH : S_IDLE;
                        end else begin
                            state <= S_WB;
                        end
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        if (tmo_hit) state <= S_ERR;
                    end
                end
                S_WB: begin
                    icount  <= icount + 1'b1;
                    tmo_cnt <= '0;
                    state   <= run ? S_FETCH : S_IDLE;
                end
                S_HALT:  state <= S_HALT;
                S_ERR:   state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath controls decoded from state and opcode class
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_src   = 2'b00;
        rf_w     = 1'b0;
        rf_rsrc1 = 2'b00;
        rf_rsrc2 = 2'b00;
        rf_data  = 2'b00;
        alu_src1 = 1'b0;
        alu_src2 = 2'b00;
        aluop    = '0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'b00;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_ARITH: begin
                        alu_src2 = 2'b00;
                        aluop    = ALUOP_W'(opcode[2:0]);
                    end
                    C_INC:   alu_src2 = 2'b10;
                    C_SHIFT: begin
                        alu_src2 = 2'b01;
                        aluop    = ALUOP_W'(opcode[2:0]);
                    end
                    C_LW, C_SW: begin
                        alu_src1 = 1'b1;
                        alu_src2 = 2'b11;
                    end
                    C_BR: begin
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                    end
                    C_CALL: begin
                        aluop    = ALUOP_W'(1);
                        rf_rsrc1 = 2'b10;
                    end
                    C_RET: begin
                        aluop    = '0;
                        rf_rsrc1 = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                case (cls)
                    C_LW, C_RET:  dm_read  = 1'b1;
                    C_SW, C_CALL: dm_write = 1'b1;
                    default: ;
                endcase
            end
            S_WB: begin
                rf_w = 1'b1;
                case (cls)
                    C_LW:    rf_data = 2'b00;
                    C_LHB:   rf_data = 2'b01;
                    C_LLB:   rf_data = 2'b10;
                    default: rf_data = 2'b11;
                endcase
                if (cls == C_CALL) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end else if (cls == C_RET) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   err    = 1'b1;
            default: ;
        endcase
    end

endmodule
